// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller and the execute-stage operand muxes.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller signal bundle. The perf counter outputs exist only
// when HAZARD_PERF_CNT_EN is defined.
interface hazard_ctrl_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic [REG_AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic              RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MemtoRegM;
  logic              BranchD, PCSrcD, MemReqM, MduE;
  logic              StallF, StallD, StallE, StallM;
  logic              FlushD, FlushE, FlushM, FlushW;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD;
  logic              MemBusy, MduBusy;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  PerfMemStall, PerfMduStall, PerfLuStall;
`endif

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    output BranchD, PCSrcD, MemReqM, MduE,
    input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemBusy, MduBusy
`ifdef HAZARD_PERF_CNT_EN
    , input PerfMemStall, PerfMduStall, PerfLuStall
`endif
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
    input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
    input  BranchD, PCSrcD, MemReqM, MduE,
    output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM, FlushW,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, MemBusy, MduBusy
`ifdef HAZARD_PERF_CNT_EN
    , output PerfMemStall, PerfMduStall, PerfLuStall
`endif
  );

endinterface

// File: rtl/hazard_wait_cnt.sv
// Multi-cycle occupancy counter: wait_o is high for the first LAT-1 cycles of an op.
// SATURATE=1 holds the count at LAT-1 while active instead of clearing it.
module hazard_wait_cnt #(
  parameter int unsigned LAT      = 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  output logic wait_o
);
  localparam int unsigned     CW   = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign wait_o = active_i & (cnt_q < LAST);

  always_comb begin
    cnt_d = '0;
    if (wait_o) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else if (active_i && SATURATE) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: forwarding selects, load-use/branch stalls, multi-cycle M/E waits.
// Define HAZARD_PERF_CNT_EN to add the stall performance counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_ctrl_unit_if.slave hz
);

  if (MEM_LAT < 1 || MDU_LAT < 1 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl_unit: MEM_LAT, MDU_LAT and CNT_W must be at least 1");
  end

  // x0 is hard-wired zero, so it never creates a dependency
  function automatic logic reg_match(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
    return (a != {REG_AW{1'b0}}) && (a == b);
  endfunction

  logic mem_wait, mdu_wait, lu, br;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_e, flush_m, flush_w;
  fwd_sel_e fwd_a, fwd_b;

  hazard_wait_cnt #(.LAT(MEM_LAT), .SATURATE(1'b0)) u_mem_cnt (
    .clk(clk), .rst(rst), .active_i(hz.MemReqM), .wait_o(mem_wait)
  );

  // The MDU count keeps running under a memory wait so the op leaves E once both clear
  hazard_wait_cnt #(.LAT(MDU_LAT), .SATURATE(1'b1)) u_mdu_cnt (
    .clk(clk), .rst(rst), .active_i(hz.MduE), .wait_o(mdu_wait)
  );

  assign lu = hz.MemtoRegE & (reg_match(hz.RdE, hz.Rs1D) | reg_match(hz.RdE, hz.Rs2D));
  assign br = hz.BranchD &
              ((hz.RegWriteE & (reg_match(hz.RdE, hz.Rs1D) | reg_match(hz.RdE, hz.Rs2D))) |
               (hz.MemtoRegM & (reg_match(hz.RdM, hz.Rs1D) | reg_match(hz.RdM, hz.Rs2D))));

  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (hz.RegWriteM && reg_match(hz.RdM, hz.Rs1E)) begin
      fwd_a = FWD_MEM;
    end else if (hz.RegWriteW && reg_match(hz.RdW, hz.Rs1E)) begin
      fwd_a = FWD_WB;
    end else begin
      fwd_a = FWD_REG;
    end
    if (hz.RegWriteM && reg_match(hz.RdM, hz.Rs2E)) begin
      fwd_b = FWD_MEM;
    end else if (hz.RegWriteW && reg_match(hz.RdW, hz.Rs2E)) begin
      fwd_b = FWD_WB;
    end else begin
      fwd_b = FWD_REG;
    end
  end

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (mem_wait) begin
      {stall_f, stall_d, stall_e, stall_m} = 4'b1111;
      flush_w = 1'b1;
    end else if (mdu_wait) begin
      {stall_f, stall_d, stall_e} = 3'b111;
      flush_m = 1'b1;
    end else if (lu || br) begin
      {stall_f, stall_d} = 2'b11;
      flush_e = 1'b1;
    end else begin
      flush_w = 1'b0;
    end
  end

  // Every output reads zero while reset is asserted
  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.ForwardAE = FWD_REG;
    hz.ForwardBE = FWD_REG;
    hz.ForwardAD = 1'b0;
    hz.ForwardBD = 1'b0;
    hz.MemBusy   = 1'b0;
    hz.MduBusy   = 1'b0;
    if (!rst) begin
      hz.StallF    = stall_f;
      hz.StallD    = stall_d;
      hz.StallE    = stall_e;
      hz.StallM    = stall_m;
      hz.FlushD    = hz.PCSrcD & ~stall_d;
      hz.FlushE    = flush_e;
      hz.FlushM    = flush_m;
      hz.FlushW    = flush_w;
      hz.ForwardAE = fwd_a;
      hz.ForwardBE = fwd_b;
      hz.ForwardAD = hz.RegWriteM & reg_match(hz.RdM, hz.Rs1D);
      hz.ForwardBD = hz.RegWriteM & reg_match(hz.RdM, hz.Rs2D);
      hz.MemBusy   = mem_wait;
      hz.MduBusy   = mdu_wait;
    end else begin
      hz.MemBusy   = 1'b0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] perf_mem_q, perf_mem_d, perf_mdu_q, perf_mdu_d, perf_lu_q, perf_lu_d;

  // Each counter charges a cycle only to the highest-priority stall cause
  always_comb begin
    perf_mem_d = perf_mem_q + CNT_W'(mem_wait);
    perf_mdu_d = perf_mdu_q + CNT_W'(mdu_wait & ~mem_wait);
    perf_lu_d  = perf_lu_q  + CNT_W'((lu | br) & ~mem_wait & ~mdu_wait);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_mem_q <= '0;
      perf_mdu_q <= '0;
      perf_lu_q  <= '0;
    end else begin
      perf_mem_q <= perf_mem_d;
      perf_mdu_q <= perf_mdu_d;
      perf_lu_q  <= perf_lu_d;
    end
  end

  assign hz.PerfMemStall = rst ? '0 : perf_mem_q;
  assign hz.PerfMduStall = rst ? '0 : perf_mdu_q;
  assign hz.PerfLuStall  = rst ? '0 : perf_lu_q;
`else
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit with MEM_LAT=3, MDU_LAT=4.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(32)) hz ();

  hazard_ctrl_unit #(.REG_AW(5), .MEM_LAT(3), .MDU_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hz(hz.slave)
  );

  // ctl = {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD, PCSrcD}
  // stall = {F,D,E,M}, flush = {D,E,M,W}
  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [6:0] ctl;
    logic [3:0] stall, flush;
    logic [1:0] fae, fbe;
    logic       fad, fbd;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                              input logic [6:0] ctl, input logic [3:0] stall, flush,
                              input logic [1:0] fae, fbe, input logic fad, fbd);
    vec_t v;
    v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.ctl = ctl;
    v.stall = stall; v.flush = flush; v.fae = fae; v.fbe = fbe; v.fad = fad; v.fbd = fbd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_seq(input string name, input logic [3:0] st, input logic [3:0] fl,
                           input logic [1:0] busy);
    check({name, " stall"}, 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM}), 32'(st));
    check({name, " flush"}, 32'({hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}), 32'(fl));
    check({name, " busy"},  32'({hz.MemBusy, hz.MduBusy}), 32'(busy));
  endtask

  task automatic clear_inputs();
    hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0;
    hz.RdE = 5'd0; hz.RdM = 5'd0; hz.RdW = 5'd0;
    {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.MemtoRegM,
     hz.BranchD, hz.PCSrcD} = 7'd0;
    hz.MemReqM = 1'b0;
    hz.MduE    = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0000000, 4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[1]  = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0001000, 4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[2]  = mk(5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 7'b0001000, 4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[3]  = mk(5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 7'b0001000, 4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[4]  = mk(5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 7'b0110000, 4'b0000, 4'b0000, 2'b10, 2'b00, 1'b0, 1'b0);
    vecs[5]  = mk(5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd7, 7'b0010000, 4'b0000, 4'b0000, 2'b01, 2'b00, 1'b0, 1'b0);
    vecs[6]  = mk(5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd9, 7'b0110000, 4'b0000, 4'b0000, 2'b00, 2'b01, 1'b0, 1'b0);
    vecs[7]  = mk(5'd3, 5'd3, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 7'b0100000, 4'b0000, 4'b0000, 2'b00, 2'b00, 1'b1, 1'b1);
    vecs[8]  = mk(5'd0, 5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 7'b1000010, 4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[9]  = mk(5'd6, 5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 7'b0100110, 4'b1100, 4'b0100, 2'b00, 2'b00, 1'b1, 1'b0);
    vecs[10] = mk(5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 7'b0000010, 4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[11] = mk(5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 7'b0001001, 4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[12] = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0000011, 4'b0000, 4'b1000, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[13] = mk(5'd2, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd0, 7'b1000011, 4'b1100, 4'b0100, 2'b00, 2'b00, 1'b0, 1'b0);
    vecs[14] = mk(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b1000010, 4'b0000, 4'b0000, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset state: inputs that would forward and stall must still yield all-zero outputs
    clear_inputs();
    hz.Rs1E = 5'd7; hz.RdM = 5'd7; hz.RegWriteM = 1'b1;
    hz.Rs1D = 5'd5; hz.RdE = 5'd5; hz.MemtoRegE = 1'b1; hz.MemReqM = 1'b1;
    @(negedge clk); @(negedge clk);
    check_seq("reset", 4'b0000, 4'b0000, 2'b00);
    check("reset fwdAE", 32'(hz.ForwardAE), 32'd0);
    rst = 1'b0;
    clear_inputs();

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      hz.Rs1D = vecs[i].rs1d; hz.Rs2D = vecs[i].rs2d; hz.Rs1E = vecs[i].rs1e;
      hz.Rs2E = vecs[i].rs2e; hz.RdE = vecs[i].rde; hz.RdM = vecs[i].rdm; hz.RdW = vecs[i].rdw;
      {hz.RegWriteE, hz.RegWriteM, hz.RegWriteW, hz.MemtoRegE, hz.MemtoRegM,
       hz.BranchD, hz.PCSrcD} = vecs[i].ctl;
      #1;
      check($sformatf("vec%0d stall/flush", i),
            32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}),
            32'({vecs[i].stall, vecs[i].flush}));
      check($sformatf("vec%0d fwd", i),
            32'({hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD}),
            32'({vecs[i].fae, vecs[i].fbe, vecs[i].fad, vecs[i].fbd}));
    end

    // Memory wait: two stall cycles then release, back-to-back op restarts the count
    @(negedge clk); clear_inputs(); hz.MemReqM = 1'b1;
    #1 check_seq("mem c0", 4'b1111, 4'b0001, 2'b10);
    @(negedge clk); #1 check_seq("mem c1", 4'b1111, 4'b0001, 2'b10);
    @(negedge clk); #1 check_seq("mem c2", 4'b0000, 4'b0000, 2'b00);
    @(negedge clk); #1 check_seq("mem b2b c0", 4'b1111, 4'b0001, 2'b10);
    @(negedge clk); #1 check_seq("mem b2b c1", 4'b1111, 4'b0001, 2'b10);
    @(negedge clk); #1 check_seq("mem b2b c2", 4'b0000, 4'b0000, 2'b00);
    @(negedge clk); hz.MemReqM = 1'b0;
    #1 check_seq("mem idle", 4'b0000, 4'b0000, 2'b00);
`ifdef HAZARD_PERF_CNT_EN
    check("perf mem after mem seq", hz.PerfMemStall, 32'd4);
    check("perf mdu after mem seq", hz.PerfMduStall, 32'd0);
`endif

    // MDU wait overlapped by a memory wait starting in its third cycle
    @(negedge clk); hz.MduE = 1'b1;
    #1 check_seq("mdu c0", 4'b1110, 4'b0010, 2'b01);
    @(negedge clk); #1 check_seq("mdu c1", 4'b1110, 4'b0010, 2'b01);
    @(negedge clk); hz.MemReqM = 1'b1;
    #1 check_seq("mdu c2 memwait", 4'b1111, 4'b0001, 2'b11);
    @(negedge clk); #1 check_seq("mdu c3 memwait", 4'b1111, 4'b0001, 2'b10);
    @(negedge clk); #1 check_seq("mdu c4 both clear", 4'b0000, 4'b0000, 2'b00);
    @(negedge clk); hz.MduE = 1'b0; hz.MemReqM = 1'b0;
    #1 check_seq("mdu idle", 4'b0000, 4'b0000, 2'b00);
    @(negedge clk); hz.MduE = 1'b1;
    #1 check_seq("mdu restart", 4'b1110, 4'b0010, 2'b01);
    @(negedge clk); hz.MduE = 1'b0;

    // Reset in the middle of a memory wait, then a full-length wait after release
    @(negedge clk); hz.MemReqM = 1'b1;
    #1 check_seq("rstseq c0", 4'b1111, 4'b0001, 2'b10);
    @(negedge clk); rst = 1'b1;
    hz.RegWriteM = 1'b1; hz.RdM = 5'd7; hz.Rs1E = 5'd7; hz.PCSrcD = 1'b1;
    #1 check_seq("rstseq in rst", 4'b0000, 4'b0000, 2'b00);
    check("rstseq fwd in rst", 32'({hz.ForwardAE, hz.ForwardBE}), 32'd0);
    @(negedge clk); rst = 1'b0;
    hz.RegWriteM = 1'b0; hz.RdM = 5'd0; hz.Rs1E = 5'd0; hz.PCSrcD = 1'b0;
    #1 check_seq("rstseq rel c0", 4'b1111, 4'b0001, 2'b10);
`ifdef HAZARD_PERF_CNT_EN
    check("perf mem after rst", hz.PerfMemStall, 32'd0);
    check("perf mdu after rst", hz.PerfMduStall, 32'd0);
    check("perf lu after rst",  hz.PerfLuStall,  32'd0);
`endif
    @(negedge clk); #1 check_seq("rstseq rel c1", 4'b1111, 4'b0001, 2'b10);
    @(negedge clk); #1 check_seq("rstseq rel c2", 4'b0000, 4'b0000, 2'b00);
    hz.MemReqM = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
